// File: rtl/collram_pkg.sv
// Shared constants and types for the collision-latch RAM.
// Read-byte bit positions, counter width and sweep FSM states.
package collram_pkg;

  localparam int RD_SM_BIT    = 7;
  localparam int RD_NBUSY_BIT = 6;
  localparam int RD_ENT_BIT   = 0;
  localparam int CNT_W        = 8;

  typedef enum logic {IDLE, SWEEP} sweep_state_t;

endpackage

// File: rtl/collram_sweep_if.sv
// CPU and video-side signals of the collision RAM, bundled into one interface.
// master drives the requests, slave is the RAM block.
interface collram_sweep_if #(parameter int AW = 10);

  logic [AW-1:0] cpu_ad;
  logic          cpu_wr_coll;
  logic          cpu_wr_collclr;
  logic          cpu_wr_clrall;
  logic [7:0]    cpu_rd_coll;
  logic [AW-1:0] coll_ad;
  logic          coll;
  logic          frame_start;
  logic          busy;
  logic [7:0]    coll_cnt;

  modport master (
    output cpu_ad, cpu_wr_coll, cpu_wr_collclr, cpu_wr_clrall,
    output coll_ad, coll, frame_start,
    input  cpu_rd_coll, busy, coll_cnt
  );

  modport slave (
    input  cpu_ad, cpu_wr_coll, cpu_wr_collclr, cpu_wr_clrall,
    input  coll_ad, coll, frame_start,
    output cpu_rd_coll, busy, coll_cnt
  );

endinterface

// File: rtl/collram_bits.sv
// 2^AW x 1 simple dual-port RAM: one write port, registered read port that
// returns the old contents when the same address is written in the same cycle.
module collram_bits #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic          wd,
  input  logic [AW-1:0] ra,
  output logic          rd
);

  logic mem [0:(1 << AW) - 1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
    rd <= mem[ra];
  end

endmodule

// File: rtl/collram_sweep.sv
// Collision-latch RAM top: write arbitration, summary flag, event counter and,
// when COLLRAM_SWEEP_EN is defined, the hardware clear-all sweep FSM.
module collram_sweep
  import collram_pkg::*;
#(
  parameter int AW       = 10,
  parameter int AUTO_CLR = 0
) (
  input  logic             clk,
  input  logic             RESET,
  collram_sweep_if.slave   bus
);

  localparam logic [AW-1:0] LAST = '1;

  logic             ram_we;
  logic             ram_wd;
  logic [AW-1:0]    ram_wa;
  logic             ram_rd;
  logic             sweep_we;
  logic             busy;
  logic             start_req;
  logic [AW-1:0]    ptr;
  logic             coll_sm;
  logic [CNT_W-1:0] coll_cnt;

`ifdef COLLRAM_SWEEP_EN
  sweep_state_t  state, state_nxt;
  logic [AW-1:0] ptr_nxt;

  assign start_req = bus.cpu_wr_clrall | ((AUTO_CLR != 0) & bus.frame_start);

  // Reset drops into SWEEP so the array clears itself after power-up.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state <= SWEEP;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sweep_we  = 1'b0;
    case (state)
      IDLE: begin
        if (start_req) begin
          state_nxt = SWEEP;
          ptr_nxt   = '0;
        end
      end
      SWEEP: begin
        sweep_we = ~bus.cpu_wr_coll & ~bus.coll;
        if (start_req) begin
          ptr_nxt = '0;
        end else if (sweep_we) begin
          if (ptr == LAST) begin
            state_nxt = IDLE;
          end else begin
            ptr_nxt = ptr + AW'(1);
          end
        end
      end
    endcase
  end

  assign busy = (state == SWEEP);
`else
  logic unused_sweep;

  assign start_req    = 1'b0;
  assign sweep_we     = 1'b0;
  assign busy         = 1'b0;
  assign ptr          = '0;
  assign unused_sweep = ^{bus.cpu_wr_clrall, bus.frame_start, (AUTO_CLR != 0)};
`endif

  // CPU clear beats a hardware set, which beats the sweep; a stalled sweep holds ptr.
  always_comb begin
    ram_we = 1'b1;
    ram_wa = bus.cpu_ad;
    ram_wd = 1'b0;
    if (bus.cpu_wr_coll) begin
      ram_wa = bus.cpu_ad;
    end else if (bus.coll) begin
      ram_wa = bus.coll_ad;
      ram_wd = 1'b1;
    end else if (sweep_we) begin
      ram_wa = ptr;
    end else begin
      ram_we = 1'b0;
    end
  end

  collram_bits #(.AW(AW)) u_bits (
    .clk (clk),
    .we  (ram_we),
    .wa  (ram_wa),
    .wd  (ram_wd),
    .ra  (bus.cpu_ad),
    .rd  (ram_rd)
  );

  // A coll still counts and sets the flag even when it loses the write port.
  always_ff @(posedge clk) begin
    if (RESET) begin
      coll_sm  <= 1'b0;
      coll_cnt <= '0;
    end else if (bus.cpu_wr_collclr | start_req) begin
      coll_sm  <= 1'b0;
      coll_cnt <= '0;
    end else if (bus.coll) begin
      coll_sm <= 1'b1;
      if (coll_cnt != '1) begin
        coll_cnt <= coll_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    bus.cpu_rd_coll               = 8'h3E;
    bus.cpu_rd_coll[RD_SM_BIT]    = coll_sm;
    bus.cpu_rd_coll[RD_NBUSY_BIT] = ~busy;
    bus.cpu_rd_coll[RD_ENT_BIT]   = ram_rd;
  end

  assign bus.busy     = busy;
  assign bus.coll_cnt = coll_cnt;

endmodule

// File: tb/tb_collram_sweep.sv
// Self-checking bench for collram_sweep (AW=6, AUTO_CLR=1) with a behavioural
// model; sweep-only duration checks are enabled when COLLRAM_SWEEP_EN is defined.
module tb_collram_sweep;

  localparam int AW       = 6;
  localparam int DEPTH    = 1 << AW;
  localparam int AUTO_CLR = 1;
`ifdef COLLRAM_SWEEP_EN
  localparam bit SWEEP_BUILD = 1'b1;
`else
  localparam bit SWEEP_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic RESET;

  always #5 clk = ~clk;

  collram_sweep_if #(.AW(AW)) bus ();

  collram_sweep #(.AW(AW), .AUTO_CLR(AUTO_CLR)) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  bit m_val   [DEPTH];
  bit m_known [DEPTH];
  bit m_sweeping;
  int m_pos;
  bit m_sm;
  int m_cnt;
  bit m_rd;
  bit m_rd_known;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_write(input int addr, input bit val);
    m_val[addr]   = val;
    m_known[addr] = 1'b1;
  endtask

  // One clock of stimulus; the model advances on the same edge and all
  // outputs are compared 1 time unit later.
  task automatic applyStimulus(input bit wr_coll, input bit coll, input int coll_ad,
                               input int cpu_ad, input bit collclr, input bit clrall,
                               input bit fs);
    bit start;
    bit owned;
    logic [7:0] exp_byte;
    bus.cpu_wr_coll    = wr_coll;
    bus.coll           = coll;
    bus.coll_ad        = coll_ad[AW-1:0];
    bus.cpu_ad         = cpu_ad[AW-1:0];
    bus.cpu_wr_collclr = collclr;
    bus.cpu_wr_clrall  = clrall;
    bus.frame_start    = fs;
    @(posedge clk);
    m_rd       = m_val[cpu_ad];
    m_rd_known = m_known[cpu_ad];
    start = SWEEP_BUILD && (clrall || ((AUTO_CLR != 0) && fs));
    owned = 1'b0;
    if (wr_coll) model_write(cpu_ad, 1'b0);
    else if (coll) model_write(coll_ad, 1'b1);
    else if (m_sweeping) begin
      model_write(m_pos, 1'b0);
      owned = 1'b1;
    end
    if (start) begin
      m_sweeping = 1'b1;
      m_pos      = 0;
    end else if (owned) begin
      if (m_pos == DEPTH - 1) m_sweeping = 1'b0;
      else m_pos++;
    end
    if (collclr || start) begin
      m_sm  = 1'b0;
      m_cnt = 0;
    end else if (coll) begin
      m_sm = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
    #1;
    exp_byte = {m_sm, ~m_sweeping, 5'b11111, m_rd};
    if (m_rd_known) checkOutput("rd_coll", bus.cpu_rd_coll, exp_byte);
    else checkOutput("rd_coll_hi", bus.cpu_rd_coll & 8'hFE, exp_byte & 8'hFE);
    checkOutput("coll_cnt", bus.coll_cnt, m_cnt);
    checkOutput("busy", bus.busy, m_sweeping);
  endtask

  task automatic idle(input int cpu_ad);
    applyStimulus(1'b0, 1'b0, 0, cpu_ad, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) idle(a);
  endtask

  task automatic wait_idle(output int busy_len);
    int guard;
    busy_len = bus.busy ? 1 : 0;
    guard = 0;
    while (bus.busy && guard < 4 * DEPTH) begin
      idle($urandom_range(0, DEPTH - 1));
      if (bus.busy) busy_len++;
      guard++;
    end
    checkOutput("busy_timeout", bus.busy, 0);
  endtask

  initial begin
    int busy_len;
    int r;
    bit w, c, cc, ca, fs;

    bus.cpu_wr_coll    = 1'b0;
    bus.coll           = 1'b0;
    bus.coll_ad        = '0;
    bus.cpu_ad         = '0;
    bus.cpu_wr_collclr = 1'b0;
    bus.cpu_wr_clrall  = 1'b0;
    bus.frame_start    = 1'b0;
    RESET = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    RESET = 1'b0;
    for (int a = 0; a < DEPTH; a++) m_known[a] = 1'b0;
    m_sweeping = SWEEP_BUILD;
    m_pos      = 0;
    m_sm       = 1'b0;
    m_cnt      = 0;
    checkOutput("reset_cnt", bus.coll_cnt, 0);
    checkOutput("reset_sm", bus.cpu_rd_coll[7], 0);

    $display("[TB] reset sweep / initial clear");
    wait_idle(busy_len);
`ifdef COLLRAM_SWEEP_EN
    checkOutput("busy_len_reset", busy_len, DEPTH);
`else
    for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, 1'b0, 0, a, 1'b0, 1'b0, 1'b0);
`endif
    read_all();
    checkOutput("idle_byte", bus.cpu_rd_coll, 8'h7E);

    $display("[TB] single collision");
    applyStimulus(1'b0, 1'b1, 8'h15, 8'h14, 1'b0, 1'b0, 1'b0);
    idle(8'h15);
    checkOutput("read_15", bus.cpu_rd_coll, 8'hFF);
    idle(8'h14);
    checkOutput("read_14", bus.cpu_rd_coll, 8'hFE);
    checkOutput("cnt_one", bus.coll_cnt, 1);

    $display("[TB] cpu clear beats collision");
    applyStimulus(1'b1, 1'b1, 8'h15, 8'h15, 1'b0, 1'b0, 1'b0);
    checkOutput("same_cycle_old", bus.cpu_rd_coll[0], 1);
    idle(8'h15);
    checkOutput("same_cycle_entry", bus.cpu_rd_coll, 8'hFE);
    checkOutput("same_cycle_cnt", bus.coll_cnt, 2);

    $display("[TB] counter saturation and collclr");
    for (int i = 0; i < 300; i++)
      applyStimulus(1'b0, 1'b1, $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                    1'b0, 1'b0, 1'b0);
    checkOutput("cnt_sat", bus.coll_cnt, 255);
    applyStimulus(1'b0, 1'b1, 3, 3, 1'b1, 1'b0, 1'b0);
    checkOutput("collclr_cnt", bus.coll_cnt, 0);
    checkOutput("collclr_sm", bus.cpu_rd_coll[7], 0);

    $display("[TB] clrall with collisions mid-sweep");
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    busy_len = bus.busy ? 1 : 0;
    for (int i = 0; i < 4 * DEPTH && bus.busy; i++) begin
      applyStimulus(1'b0, (i >= 10 && i < 20), $urandom_range(0, DEPTH - 1),
                    $urandom_range(0, DEPTH - 1), 1'b0, 1'b0, 1'b0);
      if (bus.busy) busy_len++;
    end
    checkOutput("busy_timeout", bus.busy, 0);
`ifdef COLLRAM_SWEEP_EN
    checkOutput("busy_len_clrall", busy_len, DEPTH + 10);
`endif
    read_all();

    $display("[TB] frame_start restart");
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) idle(i);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    wait_idle(busy_len);
`ifdef COLLRAM_SWEEP_EN
    checkOutput("busy_len_restart", busy_len, DEPTH);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      r  = $urandom_range(0, 99);
      w  = (r < 15);
      c  = ($urandom_range(0, 2) == 0);
      cc = ($urandom_range(0, 99) < 3);
      ca = ($urandom_range(0, 99) < 2);
      fs = ($urandom_range(0, 99) < 2);
      if (ca || fs) begin
        c  = 1'b0;
        cc = 1'b0;
      end
      applyStimulus(w, c, $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                    cc, ca, fs);
    end
    wait_idle(busy_len);
    read_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
